// File: rtl/cpu_pkg.sv
// Shared constants for the P7 core: exception codes, reset/handler PCs and the reset payload.
package cpu_pkg;

    localparam int unsigned EXC_W = 5;
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_OV = 5'd12;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam int unsigned DATA_W_DFLT = 96;
    localparam logic [DATA_W_DFLT-1:0] PAYLOAD_RESET = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// Field-storage register bank for one pipeline entry (valid, PC, delay-slot flag, exception, payload).
module pipe_skid_entry
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned EXC_W = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              d_valid,
    input  logic [31:0]       d_pc,
    input  logic              d_bd,
    input  logic [EXC_W-1:0]  d_exc,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [31:0]       q_pc,
    output logic              q_bd,
    output logic [EXC_W-1:0]  q_exc,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_pc    <= RESET_PC;
            q_bd    <= 1'b0;
            q_exc   <= '0;
            q_data  <= '0;
        end else if (we) begin
            q_valid <= d_valid;
            q_pc    <= d_pc;
            q_bd    <= d_bd;
            q_exc   <= d_exc;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, flush, req override and stall counter.
// Define PIPE_SKID_BUF_EN for a one-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W_DFLT,
    parameter int unsigned EXC_W = cpu_pkg::EXC_W,
    parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
    parameter logic [31:0] HANDLER_PC = cpu_pkg::HANDLER_PC,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [EXC_W-1:0]  in_exc_new,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [EXC_W-1:0] EXC_CLR = EXC_W'(EXC_NONE);
    localparam logic [DATA_W-1:0] DATA_CLR = DATA_W'(PAYLOAD_RESET);

    logic              out_free;
    logic [EXC_W-1:0]  ld_exc;
    logic [DATA_W-1:0] ld_data;

    logic              out_we;
    logic              nxt_valid;
    logic [31:0]       nxt_pc;
    logic              nxt_bd;
    logic [EXC_W-1:0]  nxt_exc;
    logic [DATA_W-1:0] nxt_data;

    assign out_free = !out_valid || out_ready;
    // Earliest stage's exception wins; an empty slot carries no exception or payload.
    assign ld_exc = !in_valid ? EXC_CLR : ((in_exc != EXC_CLR) ? in_exc : in_exc_new);
    assign ld_data = in_valid ? in_data : DATA_CLR;

    pipe_skid_entry #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .RESET_PC (PC_RESET)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .we      (out_we),
        .d_valid (nxt_valid),
        .d_pc    (nxt_pc),
        .d_bd    (nxt_bd),
        .d_exc   (nxt_exc),
        .d_data  (nxt_data),
        .q_valid (out_valid),
        .q_pc    (out_pc),
        .q_bd    (out_bd),
        .q_exc   (out_exc),
        .q_data  (out_data)
    );

`ifdef PIPE_SKID_BUF_EN
    logic              skid_we;
    logic              skid_d_valid;
    logic              skid_valid;
    logic [31:0]       skid_pc;
    logic              skid_bd;
    logic [EXC_W-1:0]  skid_exc;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_entry #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .RESET_PC (PC_RESET)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .we      (skid_we),
        .d_valid (skid_d_valid),
        .d_pc    (in_pc),
        .d_bd    (in_bd),
        .d_exc   (ld_exc),
        .d_data  (ld_data),
        .q_valid (skid_valid),
        .q_pc    (skid_pc),
        .q_bd    (skid_bd),
        .q_exc   (skid_exc),
        .q_data  (skid_data)
    );

    assign in_ready = !skid_valid;

    always_comb begin
        out_we       = 1'b0;
        nxt_valid    = in_valid;
        nxt_pc       = in_pc;
        nxt_bd       = in_bd;
        nxt_exc      = ld_exc;
        nxt_data     = ld_data;
        skid_we      = 1'b0;
        skid_d_valid = in_valid;
        if (req) begin
            out_we       = 1'b1;
            nxt_valid    = 1'b0;
            nxt_pc       = HANDLER_PC;
            nxt_bd       = 1'b0;
            nxt_exc      = EXC_CLR;
            nxt_data     = DATA_CLR;
            skid_we      = 1'b1;
            skid_d_valid = 1'b0;
        end else if (skid_valid) begin
            // A parked entry drains before any new input or flush bubble.
            if (out_free) begin
                out_we       = 1'b1;
                nxt_valid    = 1'b1;
                nxt_pc       = skid_pc;
                nxt_bd       = skid_bd;
                nxt_exc      = skid_exc;
                nxt_data     = skid_data;
                skid_we      = 1'b1;
                skid_d_valid = 1'b0;
            end
        end else if (flush) begin
            if (out_free) begin
                out_we    = 1'b1;
                nxt_valid = 1'b0;
                nxt_exc   = EXC_CLR;
                nxt_data  = DATA_CLR;
            end
        end else if (out_free) begin
            out_we = 1'b1;
        end else if (in_valid) begin
            skid_we = 1'b1;
        end
    end
`else
    assign in_ready = out_free;

    always_comb begin
        out_we    = 1'b0;
        nxt_valid = in_valid;
        nxt_pc    = in_pc;
        nxt_bd    = in_bd;
        nxt_exc   = ld_exc;
        nxt_data  = ld_data;
        if (req) begin
            out_we    = 1'b1;
            nxt_valid = 1'b0;
            nxt_pc    = HANDLER_PC;
            nxt_bd    = 1'b0;
            nxt_exc   = EXC_CLR;
            nxt_data  = DATA_CLR;
        end else if (in_ready) begin
            out_we = 1'b1;
            // Bubble keeps PC/BD so a later exception still reports a sensible EPC.
            if (flush) begin
                nxt_valid = 1'b0;
                nxt_exc   = EXC_CLR;
                nxt_data  = DATA_CLR;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
